// File: rtl/cipher_io_scheduler_if.sv
// Byte I/O bundle between the scheduler, the chip pins and the cipher core.
// master = scheduler side; slave = pins/core side.
interface cipher_io_scheduler_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              input_acknowledged;
  logic              output_acknowledge;
  logic [DATA_W-1:0] data_out;
  logic              output_byte_is_ready;
  logic              core_req;
  logic [DATA_W-1:0] core_byte;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic              clr_err;
  logic              timeout_err;
  logic [1:0]        interface_state;

  modport master (
    input  in_data, in_valid, output_acknowledge,
    input  core_done, core_result, clr_err,
    output input_acknowledged, data_out,
    output output_byte_is_ready, core_req,
    output core_byte, timeout_err, interface_state
  );

  modport slave (
    output in_data, in_valid, output_acknowledge,
    output core_done, core_result, clr_err,
    input  input_acknowledged, data_out,
    input  output_byte_is_ready, core_req,
    input  core_byte, timeout_err, interface_state
  );
endinterface

// File: rtl/cipher_io_scheduler.sv
// Byte I/O scheduler: four-phase input handshake, core issue/wait, output queue.
// Ports: clk, rst (async high), bus (cipher_io_scheduler_if.master).
module cipher_io_scheduler #(
  parameter int DATA_W       = 8,
  parameter int OUT_DEPTH    = 2,
  parameter int CORE_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  cipher_io_scheduler_if.master bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_CORE = 2'd2
  } interface_state_t;

  localparam int PW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int NW   = $clog2(OUT_DEPTH + 1);
  localparam int CW   = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX =
    CW'((CORE_TIMEOUT > 0) ? CORE_TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] PLAST = PW'(OUT_DEPTH - 1);
  localparam logic [NW-1:0] NFULL = NW'(OUT_DEPTH);

  interface_state_t state_q, state_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              iack_q, iack_d;
  logic [CW-1:0]     tcnt_q, tcnt_d;
  logic              err_q, err_d;
  logic              vld_s1_q, vld_s_q;
  logic              ack_s1_q, ack_s_q, ack_prev_q;
  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic              push, pop, ack_rise;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + 1'b1;
  endfunction

  assign ack_rise = ack_s_q & ~ack_prev_q;
  assign pop      = ack_rise && (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    iack_d  = iack_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    push    = 1'b0;
    // Return-to-zero phase runs regardless of FSM state.
    if (!vld_s_q) iack_d = 1'b0;
    if (bus.clr_err) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vld_s_q && !iack_q && (cnt_q != NFULL)) begin
          byte_d  = bus.in_data;
          iack_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_CORE;
        tcnt_d  = '0;
      end
      WAIT_CORE: begin
        if (bus.core_done) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (CORE_TIMEOUT != 0 && tcnt_q == TMAX) begin
          // Timeout: byte is dropped; set beats a same-cycle clear.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d  = push ? nxt(wr_q) : wr_q;
    rd_d  = pop ? nxt(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      iack_q     <= 1'b0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      vld_s1_q   <= 1'b0;
      vld_s_q    <= 1'b0;
      ack_s1_q   <= 1'b0;
      ack_s_q    <= 1'b0;
      ack_prev_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      iack_q     <= iack_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      vld_s1_q   <= bus.in_valid;
      vld_s_q    <= vld_s1_q;
      ack_s1_q   <= bus.output_acknowledge;
      ack_s_q    <= ack_s1_q;
      ack_prev_q <= ack_s_q;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      if (push) mem_q[wr_q] <= bus.core_result;
    end
  end

  assign bus.input_acknowledged   = iack_q;
  assign bus.data_out             = mem_q[rd_q];
  assign bus.output_byte_is_ready = (cnt_q != '0);
  assign bus.core_req             = (state_q == ISSUE);
  assign bus.core_byte            = byte_q;
  assign bus.timeout_err          = err_q;
  assign bus.interface_state      = state_q;
endmodule

// File: tb/tb_cipher_io_scheduler.sv
// Self-checking bench for cipher_io_scheduler with a queue-based reference.
// Bench plays both the chip user and the cipher core.
module tb_cipher_io_scheduler;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cipher_io_scheduler_if #(.DATA_W(DW)) bus ();

  cipher_io_scheduler #(
    .DATA_W(DW),
    .OUT_DEPTH(2),
    .CORE_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int req_cnt = 0;
  logic [DW-1:0] mq[$];

  always @(posedge clk) if (bus.core_req === 1'b1) req_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_q(input string tag);
    chk({tag, "_rdy"}, 32'(bus.output_byte_is_ready),
        32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, "_dout"}, 32'(bus.data_out), 32'(mq[0]));
  endtask

  task automatic raise(input logic [DW-1:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_req(input string tag, input int bound);
    int k = 0;
    while (bus.core_req !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    chk({tag, "_req"}, 32'(bus.core_req), 32'd1);
  endtask

  task automatic wait_iack_low(input string tag);
    int k = 0;
    while (bus.input_acknowledged !== 1'b0 && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_iack0"}, 32'(bus.input_acknowledged), 32'd0);
  endtask

  // Entered with core_req high; core answers lat cycles after the pulse.
  task automatic finish_core(input string tag, input logic [DW-1:0] b,
                             input logic [DW-1:0] r, input int lat);
    chk({tag, "_cbyte"}, 32'(bus.core_byte), 32'(b));
    chk({tag, "_iack1"}, 32'(bus.input_acknowledged), 32'd1);
    tick();
    chk({tag, "_pulse"}, 32'(bus.core_req), 32'd0);
    chk({tag, "_wait"}, 32'(bus.interface_state), 32'd2);
    tick(lat - 1);
    bus.core_done   = 1'b1;
    bus.core_result = r;
    tick();
    bus.core_done = 1'b0;
    mq.push_back(r);
    chk_q(tag);
    chk({tag, "_idle"}, 32'(bus.interface_state), 32'd0);
  endtask

  task automatic send(input string tag, input logic [DW-1:0] b,
                      input logic [DW-1:0] r, input int lat);
    raise(b);
    wait_req(tag, 12);
    bus.in_valid = 1'b0;
    finish_core(tag, b, r, lat);
    wait_iack_low(tag);
  endtask

  task automatic pop(input string tag, input int settle);
    bus.output_acknowledge = 1'b1;
    tick(2);
    chk_q({tag, "_pre"});
    tick();
    void'(mq.pop_front());
    chk_q({tag, "_post"});
    bus.output_acknowledge = 1'b0;
    tick(settle);
  endtask

  initial begin
    int base;
    logic [DW-1:0] b, r;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.output_acknowledge = 1'b0;
    bus.core_done = 1'b0;
    bus.core_result = '0;
    bus.clr_err = 1'b0;

    // Reset and idle
    tick(2);
    chk("rst_iack", 32'(bus.input_acknowledged), 0);
    chk("rst_dout", 32'(bus.data_out), 0);
    chk("rst_rdy", 32'(bus.output_byte_is_ready), 0);
    chk("rst_req", 32'(bus.core_req), 0);
    chk("rst_cbyte", 32'(bus.core_byte), 0);
    chk("rst_err", 32'(bus.timeout_err), 0);
    chk("rst_state", 32'(bus.interface_state), 0);
    rst = 1'b0;
    tick();
    bus.core_done = 1'b1;
    bus.core_result = 8'hEE;
    tick();
    bus.core_done = 1'b0;
    tick(2);
    chk("idle_done_rdy", 32'(bus.output_byte_is_ready), 0);
    chk("idle_state", 32'(bus.interface_state), 0);
    chk("idle_reqcnt", 32'(req_cnt), 0);

    // Single byte with exact issue latency
    raise(8'hA5);
    tick(2);
    chk("lat_early", 32'(bus.core_req), 0);
    tick();
    chk("lat_edge3", 32'(bus.core_req), 1);
    finish_core("single", 8'hA5, 8'h3C, 4);
    bus.in_valid = 1'b0;
    wait_iack_low("single");
    pop("single_pop", 3);

    // Four-phase: held in_valid gives no second request
    base = req_cnt;
    raise(8'h5A);
    wait_req("fp1", 12);
    finish_core("fp1", 8'h5A, 8'h77, 2);
    tick(10);
    chk("fp_hold_reqcnt", 32'(req_cnt), 32'(base + 1));
    chk("fp_hold_iack", 32'(bus.input_acknowledged), 1);
    bus.in_valid = 1'b0;
    wait_iack_low("fp1");
    send("fp2", 8'h11, 8'h99, 3);
    pop("fp_pop1", 3);
    pop("fp_pop2", 3);

    // Full queue blocks a third accept
    send("full1", 8'hC1, 8'h01, 2);
    send("full2", 8'hC2, 8'h02, 2);
    base = req_cnt;
    raise(8'hC3);
    tick(12);
    chk("full_iack", 32'(bus.input_acknowledged), 0);
    chk("full_reqcnt", 32'(req_cnt), 32'(base));
    pop("full_pop1", 0);
    wait_req("full3", 12);
    bus.in_valid = 1'b0;
    finish_core("full3", 8'hC3, 8'h03, 3);
    wait_iack_low("full3");
    pop("full_pop2", 3);
    pop("full_pop3", 3);

    // Push and pop on the same edge
    send("sim1", 8'h21, 8'h44, 2);
    raise(8'h22);
    wait_req("sim2", 12);
    bus.in_valid = 1'b0;
    chk("sim2_cbyte", 32'(bus.core_byte), 32'h22);
    tick();
    bus.output_acknowledge = 1'b1;
    tick(2);
    bus.core_done = 1'b1;
    bus.core_result = 8'h55;
    tick();
    bus.core_done = 1'b0;
    void'(mq.pop_front());
    mq.push_back(8'h55);
    chk_q("sim_both");
    bus.output_acknowledge = 1'b0;
    tick(3);
    chk_q("sim_after");
    pop("sim_pop", 3);

    // Randomized traffic
    for (int i = 0; i < 16; i++) begin
      b = DW'($urandom);
      r = DW'($urandom);
      if (mq.size() == 2) pop("rnd_popf", 3);
      send("rnd", b, r, $urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) pop("rnd_pop", 3);
    end
    while (mq.size() != 0) pop("drain", 3);

    // Core timeout
    raise(8'h70);
    wait_req("to", 12);
    bus.in_valid = 1'b0;
    tick();
    chk("to_wait", 32'(bus.interface_state), 2);
    tick(7);
    chk("to_wait7", 32'(bus.interface_state), 2);
    chk("to_err0", 32'(bus.timeout_err), 0);
    tick();
    chk("to_idle", 32'(bus.interface_state), 0);
    chk("to_err1", 32'(bus.timeout_err), 1);
    chk_q("to_drop");
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("to_clr", 32'(bus.timeout_err), 0);
    wait_iack_low("to");

    // Timeout coinciding with clr_err: set wins
    raise(8'h71);
    wait_req("to2", 12);
    bus.in_valid = 1'b0;
    bus.clr_err = 1'b1;
    tick(9);
    chk("to2_setwins", 32'(bus.timeout_err), 1);
    tick();
    bus.clr_err = 1'b0;
    chk("to2_clr", 32'(bus.timeout_err), 0);
    wait_iack_low("to2");

    // Reset during WAIT_CORE
    send("rs1", 8'h31, 8'h66, 2);
    raise(8'h32);
    wait_req("rs2", 12);
    bus.in_valid = 1'b0;
    tick(2);
    chk("rs_wait", 32'(bus.interface_state), 2);
    rst = 1'b1;
    #1;
    mq.delete();
    chk("rs_iack", 32'(bus.input_acknowledged), 0);
    chk("rs_dout", 32'(bus.data_out), 0);
    chk("rs_rdy", 32'(bus.output_byte_is_ready), 0);
    chk("rs_req", 32'(bus.core_req), 0);
    chk("rs_cbyte", 32'(bus.core_byte), 0);
    chk("rs_state", 32'(bus.interface_state), 0);
    tick();
    rst = 1'b0;
    tick();
    bus.core_done = 1'b1;
    bus.core_result = 8'h88;
    tick();
    bus.core_done = 1'b0;
    tick(3);
    chk("rs_late_rdy", 32'(bus.output_byte_is_ready), 0);
    chk("rs_late_state", 32'(bus.interface_state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
